// File: rtl/data_bus_if.sv
// Data-bus handshake bundle between the memory-stage controller and the bus.
// master: the controller drives the request side and receives the completion side.
// slave : the bus/memory side, with the directions reversed.
//   data_req_o     request valid (held until data_addr_ok_i)
//   data_wr_o      1 = store, 0 = load
//   data_size_o    0 = byte, 1 = half, 2 = word
//   data_addr_o    byte address
//   data_wdata_o   store data, replicated across lanes
//   data_be_o      byte-lane enables (stores only)
//   data_addr_ok_i request accepted
//   data_data_ok_i transfer complete
//   data_rdata_i   load data
interface data_bus_if;
    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [3:0]  data_be_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o, data_be_o,
        input  data_addr_ok_i, data_data_ok_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o, data_be_o,
        output data_addr_ok_i, data_data_ok_i, data_rdata_i
    );
endinterface

// File: rtl/data_bus_ctrl.sv
// Memory-stage bus controller: turns EXE load/store ops into a two-phase
// (address / data) bus transaction, stalls the pipeline while it is in flight,
// extracts and extends load data, and reports misaligned accesses.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   aluop_i              operation code from EXE
//   mem_addr_i, reg2_i   effective address, store data
//   wdata_i, wd_i, wreg_i  non-memory result, destination, write enable
//   flush                kills the current op
//   bus                  data-bus handshake (master side)
//   wdata_o, wd_o, wreg_o, stallreq_o  pipeline-side result and stall
//   adel_o, ades_o, badvaddr_o         address-error reporting
module data_bus_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        flush,
    data_bus_if.master  bus,
    output logic [31:0] wdata_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic        stallreq_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic [31:0] badvaddr_o
);
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, DRAIN} state_t;

    state_t      state;
    logic [31:0] load_q;
    logic        is_load_q;

    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        misaligned;
    logic        aligned_mem;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;

    // Op decode, alignment check and load-data extraction from the addressed lane.
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        unique case (aluop_i)
            EXE_LB_OP, EXE_LBU_OP: is_load = 1'b1;
            EXE_LH_OP, EXE_LHU_OP: begin is_load = 1'b1;  misaligned = mem_addr_i[0]; end
            EXE_LW_OP:             begin is_load = 1'b1;  misaligned = |mem_addr_i[1:0]; end
            EXE_SB_OP:             is_store = 1'b1;
            EXE_SH_OP:             begin is_store = 1'b1; misaligned = mem_addr_i[0]; end
            EXE_SW_OP:             begin is_store = 1'b1; misaligned = |mem_addr_i[1:0]; end
            default:               ;
        endcase
        is_mem      = is_load | is_store;
        aligned_mem = is_mem & ~misaligned;

        unique case (mem_addr_i[1:0])
            2'd0:    lane_byte = bus.data_rdata_i[7:0];
            2'd1:    lane_byte = bus.data_rdata_i[15:8];
            2'd2:    lane_byte = bus.data_rdata_i[23:16];
            default: lane_byte = bus.data_rdata_i[31:24];
        endcase
        lane_half = mem_addr_i[1] ? bus.data_rdata_i[31:16] : bus.data_rdata_i[15:0];

        unique case (aluop_i)
            EXE_LB_OP:  load_ext = {{24{lane_byte[7]}}, lane_byte};
            EXE_LBU_OP: load_ext = {24'h0, lane_byte};
            EXE_LH_OP:  load_ext = {{16{lane_half[15]}}, lane_half};
            EXE_LHU_OP: load_ext = {16'h0, lane_half};
            default:    load_ext = bus.data_rdata_i;
        endcase
    end

    // Transaction FSM plus captured load data. A data_ok that coincides with a
    // flush ends the transfer outright, since no further data_ok will follow.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            load_q    <= 32'h0;
            is_load_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (aligned_mem && !flush) begin
                        state     <= ADDR;
                        is_load_q <= is_load;
                    end
                end
                ADDR: begin
                    if (bus.data_addr_ok_i) begin
                        if (bus.data_data_ok_i) begin
                            state <= flush ? IDLE : DONE;
                            if (!flush && is_load_q) load_q <= load_ext;
                        end else begin
                            state <= flush ? DRAIN : DATA;
                        end
                    end else if (flush) begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (bus.data_data_ok_i) begin
                        state <= flush ? IDLE : DONE;
                        if (!flush && is_load_q) load_q <= load_ext;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DONE:    state <= IDLE;
                DRAIN:   if (bus.data_data_ok_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus lane formatting and pipeline-side outputs.
    always_comb begin
        bus.data_req_o   = 1'b0;
        bus.data_wr_o    = is_store;
        bus.data_addr_o  = mem_addr_i;
        bus.data_size_o  = 2'd0;
        bus.data_wdata_o = reg2_i;
        bus.data_be_o    = 4'b0000;
        wdata_o          = wdata_i;
        wd_o             = wd_i;
        wreg_o           = 1'b0;
        stallreq_o       = 1'b0;
        adel_o           = 1'b0;
        ades_o           = 1'b0;
        badvaddr_o       = 32'h0;

        unique case (aluop_i)
            EXE_LH_OP, EXE_LHU_OP: bus.data_size_o = 2'd1;
            EXE_LW_OP:             bus.data_size_o = 2'd2;
            EXE_SB_OP: begin
                bus.data_wdata_o = {4{reg2_i[7:0]}};
                bus.data_be_o    = 4'(4'b0001 << mem_addr_i[1:0]);
            end
            EXE_SH_OP: begin
                bus.data_size_o  = 2'd1;
                bus.data_wdata_o = {2{reg2_i[15:0]}};
                bus.data_be_o    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
            end
            EXE_SW_OP: begin
                bus.data_size_o  = 2'd2;
                bus.data_be_o    = 4'b1111;
            end
            default: ;
        endcase

        unique case (state)
            IDLE, DRAIN: begin
                if (!is_mem) wreg_o = wreg_i;
                // A new op waits out a drain; an idle op stalls while it is issued.
                stallreq_o = aligned_mem & ~flush;
                if (is_mem && misaligned && !flush) begin
                    adel_o     = is_load;
                    ades_o     = is_store;
                    badvaddr_o = mem_addr_i;
                end
            end
            ADDR: begin
                bus.data_req_o = 1'b1;
                stallreq_o     = 1'b1;
            end
            DATA:    stallreq_o = 1'b1;
            DONE: begin
                wdata_o = load_q;
                wreg_o  = is_load_q & wreg_i;
            end
            default: ;
        endcase

        if (flush) wreg_o = 1'b0;

        // Reset silences the bus and pipeline handshakes in the same cycle.
        if (!resetn) begin
            bus.data_req_o = 1'b0;
            stallreq_o     = 1'b0;
            wreg_o         = 1'b0;
            adel_o         = 1'b0;
            ades_o         = 1'b0;
            badvaddr_o     = 32'h0;
        end
    end
endmodule

// File: tb/tb_data_bus_ctrl.sv
// Self-checking bench for data_bus_ctrl: table of directed transactions,
// hand-written flush/reset sequences and randomized ops against a lane model.
module tb_data_bus_ctrl;
    localparam logic [7:0] OP_LB   = 8'hE0;
    localparam logic [7:0] OP_LBU  = 8'hE4;
    localparam logic [7:0] OP_LH   = 8'hE1;
    localparam logic [7:0] OP_LHU  = 8'hE5;
    localparam logic [7:0] OP_LW   = 8'hE3;
    localparam logic [7:0] OP_SB   = 8'hE8;
    localparam logic [7:0] OP_SH   = 8'hE9;
    localparam logic [7:0] OP_SW   = 8'hEB;
    localparam logic [7:0] OP_ADDU = 8'h21;

    logic        clk;
    logic        resetn;
    logic [7:0]  aluop;
    logic [31:0] mem_addr;
    logic [31:0] reg2;
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic        flush;
    logic [31:0] wdata_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic        stallreq_o;
    logic        adel_o;
    logic        ades_o;
    logic [31:0] badvaddr_o;

    data_bus_if bus ();

    data_bus_ctrl dut (
        .clk(clk), .resetn(resetn), .aluop_i(aluop), .mem_addr_i(mem_addr),
        .reg2_i(reg2), .wdata_i(wdata), .wd_i(wd), .wreg_i(wreg), .flush(flush),
        .bus(bus), .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .stallreq_o(stallreq_o), .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdata;
        int          aw;
        int          dw;
        logic [1:0]  size;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] res;
        logic        ld;
        logic        adel;
        logic        ades;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        aluop = OP_ADDU; mem_addr = 32'h0; reg2 = 32'h0; wdata = 32'h0;
        wd = 5'd0; wreg = 1'b0; flush = 1'b0;
        bus.data_addr_ok_i = 1'b0; bus.data_data_ok_i = 1'b0; bus.data_rdata_i = 32'h0;
    endtask

    // Full aligned transaction: aw refused ADDR cycles, then dw DATA cycles
    // (dw==0 means data_ok arrives together with addr_ok).
    task automatic mem_txn(input string nm, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] r2, input logic [31:0] rd, input int aw, input int dw,
                           input logic [1:0] esz, input logic [3:0] ebe, input logic [31:0] ebwd,
                           input logic [31:0] eres, input logic ld);
        aluop = op; mem_addr = addr; reg2 = r2; wdata = 32'h0BAD0BAD;
        wd = 5'd7; wreg = 1'b1; flush = 1'b0;
        bus.data_addr_ok_i = 1'b0; bus.data_data_ok_i = 1'b0; bus.data_rdata_i = ~rd;
        @(negedge clk);
        chk({nm, " idle stall"}, 32'(stallreq_o), 32'd1);
        chk({nm, " idle req"}, 32'(bus.data_req_o), 32'd0);
        chk({nm, " idle wreg"}, 32'(wreg_o), 32'd0);
        tick();
        for (int i = 0; i <= aw; i++) begin
            bus.data_addr_ok_i = (i == aw);
            bus.data_data_ok_i = (i == aw) && (dw == 0);
            bus.data_rdata_i   = ((i == aw) && (dw == 0)) ? rd : ~rd;
            @(negedge clk);
            chk({nm, " addr req"}, 32'(bus.data_req_o), 32'd1);
            chk({nm, " addr stall"}, 32'(stallreq_o), 32'd1);
            chk({nm, " addr addr"}, bus.data_addr_o, addr);
            chk({nm, " addr size"}, 32'(bus.data_size_o), 32'(esz));
            chk({nm, " addr wr"}, 32'(bus.data_wr_o), 32'(!ld));
            chk({nm, " addr be"}, 32'(bus.data_be_o), 32'(ebe));
            if (!ld) chk({nm, " addr wdata"}, bus.data_wdata_o, ebwd);
            tick();
        end
        for (int j = 1; j <= dw; j++) begin
            bus.data_addr_ok_i = 1'b0;
            bus.data_data_ok_i = (j == dw);
            bus.data_rdata_i   = (j == dw) ? rd : ~rd;
            @(negedge clk);
            chk({nm, " data req"}, 32'(bus.data_req_o), 32'd0);
            chk({nm, " data stall"}, 32'(stallreq_o), 32'd1);
            tick();
        end
        bus.data_addr_ok_i = 1'b0; bus.data_data_ok_i = 1'b0; bus.data_rdata_i = ~rd;
        @(negedge clk);
        chk({nm, " done stall"}, 32'(stallreq_o), 32'd0);
        chk({nm, " done req"}, 32'(bus.data_req_o), 32'd0);
        chk({nm, " done wreg"}, 32'(wreg_o), 32'(ld));
        chk({nm, " done wd"}, 32'(wd_o), 32'd7);
        if (ld) chk({nm, " done wdata"}, wdata_o, eres);
        tick();
        set_nop();
        @(negedge clk);
        chk({nm, " after req"}, 32'(bus.data_req_o), 32'd0);
        chk({nm, " after stall"}, 32'(stallreq_o), 32'd0);
        tick();
    endtask

    task automatic misal(input string nm, input logic [7:0] op, input logic [31:0] addr,
                         input logic eadel, input logic eades);
        aluop = op; mem_addr = addr; reg2 = 32'h55AA55AA; wd = 5'd3; wreg = 1'b1; flush = 1'b0;
        @(negedge clk);
        chk({nm, " adel"}, 32'(adel_o), 32'(eadel));
        chk({nm, " ades"}, 32'(ades_o), 32'(eades));
        chk({nm, " badvaddr"}, badvaddr_o, addr);
        chk({nm, " stall"}, 32'(stallreq_o), 32'd0);
        chk({nm, " req"}, 32'(bus.data_req_o), 32'd0);
        chk({nm, " wreg"}, 32'(wreg_o), 32'd0);
        tick();
        @(negedge clk);
        chk({nm, " req later"}, 32'(bus.data_req_o), 32'd0);
        tick();
        set_nop();
    endtask

    // Reference: access width, direction and signedness of a memory op.
    function automatic void op_info(input logic [7:0] op, output int nb, output bit ld,
                                    output bit sg, output bit mem);
        nb = 4; ld = 1'b0; sg = 1'b0; mem = 1'b1;
        case (op)
            OP_LB:   begin nb = 1; ld = 1'b1; sg = 1'b1; end
            OP_LBU:  begin nb = 1; ld = 1'b1; end
            OP_LH:   begin nb = 2; ld = 1'b1; sg = 1'b1; end
            OP_LHU:  begin nb = 2; ld = 1'b1; end
            OP_LW:   ld = 1'b1;
            OP_SB:   nb = 1;
            OP_SH:   nb = 2;
            OP_SW:   nb = 4;
            default: mem = 1'b0;
        endcase
    endfunction

    logic [7:0]  ops[9];
    logic [7:0]  r_op;
    logic [31:0] r_addr, r_r2, r_rd, r_mask, r_res, r_bwd, r_wd32;
    logic [3:0]  r_be;
    logic [1:0]  r_sz;
    int          r_nb, r_sh;
    bit          r_ld, r_sg, r_mem;

    initial begin
        n_cmp = 0;
        n_err = 0;
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_ADDU};

        tbl[0]  = '{OP_LB,  32'h1003, 32'h0,        32'h80AA5511, 0, 2, 2'd0, 4'b0000, 32'h0,        32'hFFFFFF80, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{OP_LBU, 32'h0001, 32'h0,        32'h80AA5511, 1, 1, 2'd0, 4'b0000, 32'h0,        32'h00000055, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{OP_LH,  32'h0002, 32'h0,        32'h80AA5511, 0, 0, 2'd1, 4'b0000, 32'h0,        32'hFFFF80AA, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{OP_LHU, 32'h0000, 32'h0,        32'h0000F00F, 0, 0, 2'd1, 4'b0000, 32'h0,        32'h0000F00F, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{OP_LW,  32'h0004, 32'h0,        32'hDEADBEEF, 2, 1, 2'd2, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{OP_LB,  32'h0000, 32'h0,        32'h1234567F, 0, 1, 2'd0, 4'b0000, 32'h0,        32'h0000007F, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{OP_SB,  32'h0002, 32'h123456C3, 32'h0,        0, 1, 2'd0, 4'b0100, 32'hC3C3C3C3, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[7]  = '{OP_SH,  32'h2002, 32'h1234ABCD, 32'h0,        1, 0, 2'd1, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[8]  = '{OP_SW,  32'h0008, 32'hCAFEF00D, 32'h0,        0, 2, 2'd2, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[9]  = '{OP_SH,  32'h0000, 32'hFFFF0001, 32'h0,        0, 0, 2'd1, 4'b0011, 32'h00010001, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[10] = '{OP_LW,  32'h3001, 32'h0,        32'h0,        0, 0, 2'd2, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0};
        tbl[11] = '{OP_SH,  32'h0005, 32'h0,        32'h0,        0, 0, 2'd1, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1};
        tbl[12] = '{OP_LH,  32'h0007, 32'h0,        32'h0,        0, 0, 2'd1, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0};
        tbl[13] = '{OP_SW,  32'h0002, 32'h0,        32'h0,        0, 0, 2'd2, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1};

        // Reset: handshakes and error flags silent even with ops presented.
        set_nop();
        resetn = 1'b0;
        aluop = OP_LW; mem_addr = 32'h1; wreg = 1'b1;
        @(negedge clk);
        chk("rst req", 32'(bus.data_req_o), 32'd0);
        chk("rst stall", 32'(stallreq_o), 32'd0);
        chk("rst adel", 32'(adel_o), 32'd0);
        chk("rst wreg", 32'(wreg_o), 32'd0);
        tick();
        mem_addr = 32'h0;
        @(negedge clk);
        chk("rst aligned stall", 32'(stallreq_o), 32'd0);
        chk("rst aligned req", 32'(bus.data_req_o), 32'd0);
        tick();
        resetn = 1'b1;
        set_nop();
        tick();

        // Directed vectors.
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].adel || tbl[i].ades)
                misal($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].adel, tbl[i].ades);
            else
                mem_txn($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].reg2, tbl[i].rdata,
                        tbl[i].aw, tbl[i].dw, tbl[i].size, tbl[i].be, tbl[i].bwd, tbl[i].res, tbl[i].ld);
        end

        // Flush in IDLE: op ignored, no write-back.
        aluop = OP_LW; mem_addr = 32'h40; wreg = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush idle stall", 32'(stallreq_o), 32'd0);
        chk("flush idle wreg", 32'(wreg_o), 32'd0);
        tick();
        @(negedge clk);
        chk("flush idle req", 32'(bus.data_req_o), 32'd0);
        aluop = OP_ADDU;
        #1;
        @(negedge clk);
        chk("flush nonmem wreg", 32'(wreg_o), 32'd0);
        tick();
        set_nop();

        // Flush in ADDR without addr_ok: request dropped next cycle.
        aluop = OP_SW; mem_addr = 32'h44; reg2 = 32'h1;
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush addr req", 32'(bus.data_req_o), 32'd1);
        tick();
        set_nop();
        @(negedge clk);
        chk("flush addr req drop", 32'(bus.data_req_o), 32'd0);
        chk("flush addr stall", 32'(stallreq_o), 32'd0);
        tick();

        // Flush in DATA, then a new LW waits out the drain.
        aluop = OP_LW; mem_addr = 32'h10; wreg = 1'b1; wd = 5'd9; wdata = 32'h5A5A5A5A;
        tick();
        bus.data_addr_ok_i = 1'b1;
        tick();
        bus.data_addr_ok_i = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("drain data stall", 32'(stallreq_o), 32'd1);
        tick();
        flush = 1'b0; mem_addr = 32'h20; bus.data_rdata_i = 32'h11111111;
        @(negedge clk);
        chk("drain req", 32'(bus.data_req_o), 32'd0);
        chk("drain stall", 32'(stallreq_o), 32'd1);
        tick();
        bus.data_data_ok_i = 1'b1; bus.data_rdata_i = 32'hBADBAD00;
        @(negedge clk);
        chk("drain exit req", 32'(bus.data_req_o), 32'd0);
        chk("drain exit wdata", wdata_o, 32'h5A5A5A5A);
        chk("drain exit wreg", 32'(wreg_o), 32'd0);
        tick();
        bus.data_data_ok_i = 1'b0;
        @(negedge clk);
        chk("post drain req", 32'(bus.data_req_o), 32'd0);
        chk("post drain stall", 32'(stallreq_o), 32'd1);
        tick();
        bus.data_addr_ok_i = 1'b1; bus.data_data_ok_i = 1'b1; bus.data_rdata_i = 32'h13572468;
        @(negedge clk);
        chk("new lw req", 32'(bus.data_req_o), 32'd1);
        chk("new lw addr", bus.data_addr_o, 32'h20);
        tick();
        bus.data_addr_ok_i = 1'b0; bus.data_data_ok_i = 1'b0; bus.data_rdata_i = 32'hBADBAD00;
        @(negedge clk);
        chk("new lw wdata", wdata_o, 32'h13572468);
        chk("new lw stall", 32'(stallreq_o), 32'd0);
        chk("new lw wreg", 32'(wreg_o), 32'd1);
        tick();
        set_nop();
        tick();

        // Reset asserted while in ADDR.
        aluop = OP_LW; mem_addr = 32'h30; wreg = 1'b1;
        tick();
        resetn = 1'b0;
        @(negedge clk);
        chk("rst addr req", 32'(bus.data_req_o), 32'd0);
        chk("rst addr stall", 32'(stallreq_o), 32'd0);
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("rst back idle req", 32'(bus.data_req_o), 32'd0);
        chk("rst back idle stall", 32'(stallreq_o), 32'd1);
        tick();
        bus.data_addr_ok_i = 1'b1; bus.data_data_ok_i = 1'b1; bus.data_rdata_i = 32'h0F0F0F0F;
        @(negedge clk);
        chk("rst reissue req", 32'(bus.data_req_o), 32'd1);
        tick();
        bus.data_addr_ok_i = 1'b0; bus.data_data_ok_i = 1'b0;
        @(negedge clk);
        chk("rst reissue wdata", wdata_o, 32'h0F0F0F0F);
        tick();
        set_nop();
        tick();

        // Randomized ops against the lane model.
        for (int k = 0; k < 40; k++) begin
            r_op = ops[$urandom_range(0, 8)];
            r_addr = $urandom;
            r_r2 = $urandom;
            r_rd = $urandom;
            op_info(r_op, r_nb, r_ld, r_sg, r_mem);
            if (!r_mem) begin
                r_wd32 = $urandom;
                aluop = r_op; wdata = r_r2; wd = r_wd32[4:0]; wreg = r_wd32[5]; mem_addr = r_addr;
                @(negedge clk);
                chk("rnd pass wdata", wdata_o, r_r2);
                chk("rnd pass wd", 32'(wd_o), 32'(r_wd32[4:0]));
                chk("rnd pass wreg", 32'(wreg_o), 32'(r_wd32[5]));
                chk("rnd pass stall", 32'(stallreq_o), 32'd0);
                chk("rnd pass req", 32'(bus.data_req_o), 32'd0);
                tick();
                set_nop();
            end else if ((r_addr % 32'(r_nb)) != 0) begin
                misal("rnd misal", r_op, r_addr, r_ld, !r_ld);
            end else begin
                r_sh   = 8 * int'(r_addr % 4);
                r_mask = (r_nb == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * r_nb)) - 32'd1);
                r_res  = (r_rd >> r_sh) & r_mask;
                if (r_sg && r_res[8 * r_nb - 1]) r_res = r_res | ~r_mask;
                r_bwd  = (r_r2 & r_mask) * ((r_nb == 1) ? 32'h01010101 : (r_nb == 2) ? 32'h00010001 : 32'h1);
                r_be   = r_ld ? 4'b0000 : 4'(((32'd1 << r_nb) - 32'd1) << (r_addr % 4));
                r_sz   = (r_nb == 1) ? 2'd0 : (r_nb == 2) ? 2'd1 : 2'd2;
                mem_txn("rnd txn", r_op, r_addr, r_r2, r_rd, $urandom_range(0, 2), $urandom_range(0, 2),
                        r_sz, r_be, r_bwd, r_res, r_ld);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
